pc_gen: RTL

Parametrised program-counter generator for the fetch stage of the pipelined RV32 core, replacing the plain stall-gated PC register. It produces the fetch address each cycle and selects the next PC from five sources: trap vector, branch/jump redirect from EX, a redirect deferred while stalled, a BTB prediction, or sequential increment. It holds the PC under stall without losing redirects that arrive during the stall, and it marks the first post-reset fetch.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 37 +++
 rtl/pc_gen_btb.sv | 60 ++++++
 rtl/pc_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen shared types: FSM state and BTB entry layout.
// Shared by the top, the BTB and the bench.
package pc_gen_pkg;

  localparam int unsigned BTB_W = 64;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [BTB_W-1:0] tag;
    logic [BTB_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline and pc_gen.
// master drives the controls, slave is the PC generator.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);

  logic            i_stall;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_trap_valid;
  logic [XLEN-1:0] i_trap_pc;
  logic            i_upd_valid;
  logic [XLEN-1:0] i_upd_pc;
  logic [XLEN-1:0] i_upd_target;
  logic            i_upd_taken;
  logic [XLEN-1:0] o_pc;
  logic            o_pc_valid;
  logic            o_pred_taken;
  logic            o_misaligned;

  modport master (
    output i_stall, i_redirect_valid, i_redirect_pc,
    output i_trap_valid, i_trap_pc,
    output i_upd_valid, i_upd_pc, i_upd_target,
    output i_upd_taken,
    input  o_pc, o_pc_valid, o_pred_taken, o_misaligned
  );

  modport slave (
    input  i_stall, i_redirect_valid, i_redirect_pc,
    input  i_trap_valid, i_trap_pc,
    input  i_upd_valid, i_upd_pc, i_upd_target,
    input  i_upd_taken,
    output o_pc, o_pc_valid, o_pred_taken, o_misaligned
  );

endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer for pc_gen.
// Lookup is combinational; updates land on the clock edge.
module pc_gen_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int unsigned OFF_W = $clog2(INSTR_BYTES);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned SH    = OFF_W + IDX_W;

  btb_entry_t mem [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [BTB_W-1:0] rd_tag;
  logic [BTB_W-1:0] wr_tag;
  btb_entry_t       rd;

  assign rd_idx = i_pc[SH-1:OFF_W];
  assign wr_idx = i_upd_pc[SH-1:OFF_W];
  assign rd_tag = BTB_W'(i_pc >> SH);
  assign wr_tag = BTB_W'(i_upd_pc >> SH);
  assign rd     = mem[rd_idx];

  // Lookup sees pre-update contents (write-after-read)
  assign o_hit    = rd.valid && (rd.tag == rd_tag);
  assign o_target = XLEN'(rd.target);

  // Install taken branches, evict on not-taken tag hit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (i_upd_valid) begin
      if (i_upd_taken) begin
        mem[wr_idx].valid  <= 1'b1;
        mem[wr_idx].tag    <= wr_tag;
        mem[wr_idx].target <= BTB_W'(i_upd_target);
      end else if (mem[wr_idx].tag == wr_tag) begin
        mem[wr_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap, redirect, deferred redirect, BTB, sequential.
// Optional BTB built when PC_GEN_BTB_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input logic    i_clk,
  input logic    i_rst,
  pc_gen_if.slave bus
);

  localparam logic [XLEN-1:0] LOW = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);

  function automatic logic [XLEN-1:0] align(
    input logic [XLEN-1:0] a
  );
    return a & ~LOW;
  endfunction

  function automatic logic mis(input logic [XLEN-1:0] a);
    return |(a & LOW);
  endfunction

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pend, pend_nxt;
  logic            pmis, pmis_nxt;
  logic            misr, mis_nxt;
  logic            btb_hit;
  logic [XLEN-1:0] btb_tgt;

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pc         (pc),
    .o_hit        (btb_hit),
    .o_target     (btb_tgt),
    .i_upd_valid  (bus.i_upd_valid),
    .i_upd_pc     (bus.i_upd_pc),
    .i_upd_target (bus.i_upd_target),
    .i_upd_taken  (bus.i_upd_taken)
  );
`else
  logic unused_upd;
  assign unused_upd = ^{bus.i_upd_valid, bus.i_upd_pc,
                        bus.i_upd_target, bus.i_upd_taken};
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;
`endif

  logic stall, rdv, trv;
  assign stall = bus.i_stall;
  assign rdv   = bus.i_redirect_valid;
  assign trv   = bus.i_trap_valid;

  // Next-PC select by priority within each state
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend;
    pmis_nxt  = pmis;
    mis_nxt   = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trv) begin
          pc_nxt  = align(bus.i_trap_pc);
          mis_nxt = mis(bus.i_trap_pc);
        end else if (rdv && !stall) begin
          pc_nxt  = align(bus.i_redirect_pc);
          mis_nxt = mis(bus.i_redirect_pc);
        end else if (rdv) begin
          pend_nxt  = align(bus.i_redirect_pc);
          pmis_nxt  = mis(bus.i_redirect_pc);
          state_nxt = HOLD;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (btb_hit) begin
          pc_nxt = align(btb_tgt);
        end else begin
          pc_nxt = pc + INC;
        end
      end
      HOLD: begin
        if (trv) begin
          pc_nxt    = align(bus.i_trap_pc);
          mis_nxt   = mis(bus.i_trap_pc);
          pend_nxt  = '0;
          pmis_nxt  = 1'b0;
          state_nxt = RUN;
        end else if (stall) begin
          if (rdv) begin
            pend_nxt = align(bus.i_redirect_pc);
            pmis_nxt = mis(bus.i_redirect_pc);
          end
        end else begin
          if (rdv) begin
            pc_nxt  = align(bus.i_redirect_pc);
            mis_nxt = mis(bus.i_redirect_pc);
          end else begin
            pc_nxt  = pend;
            mis_nxt = pmis;
          end
          pend_nxt  = '0;
          pmis_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC, pending redirect and misalign pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      pend  <= '0;
      pmis  <= 1'b0;
      misr  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
      pmis  <= pmis_nxt;
      misr  <= mis_nxt;
    end
  end

  assign bus.o_pc         = pc;
  assign bus.o_pc_valid   = (state != BOOT);
  assign bus.o_misaligned = misr;
  assign bus.o_pred_taken = (state == RUN) && btb_hit &&
                            !stall && !rdv && !trv;

endmodule
